requant_unit: RTL

- Post-processing stage directly downstream of the INT8 MAC unit. Consumes each final signed ACC_WIDTH accumulator result and converts it to one signed INT8 activation for the next layer.
- Conversion steps: bias add, fixed-point multiply, rounding right shift, zero-point add, saturation.
- Three-stage pipeline with valid/ready handshakes on both sides and per-stage bubble collapse.
- The upstream controller asserts acc_valid only for final dot-product results, never for partial sums.

---
 rtl/requant_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/requant_unit.sv
// requant_unit: 3-stage INT8 requantizer (bias add, multiply, round-half-up shift, zero point, clamp).
// Define REQUANT_RELU_EN to raise the lower clamp bound to the zero point (fused ReLU).
module requant_unit #(
  parameter int ACC_WIDTH   = 32,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  input  logic signed [MULT_WIDTH-1:0] mult,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  input  logic signed [7:0]            zero_point,
  output logic signed [7:0]            q_out,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic                         sat_flag,
  output logic [CNT_WIDTH-1:0]         sat_count,
  input  logic                         sat_clr
);
  localparam int SW = ACC_WIDTH + 1;
  localparam int PW = SW + MULT_WIDTH;
  localparam int RW = PW + 1;
  localparam int VW = RW + 1;
  logic                         v1, v2, rdy1, rdy2, rdy3, sat_xfer, sat_nx;
  logic signed [SW-1:0]         sum1;
  logic signed [MULT_WIDTH-1:0] mult1;
  logic [SHIFT_WIDTH-1:0]       sh1, sh2;
  logic signed [7:0]            zp1, zp2, q_nx;
  logic signed [PW-1:0]         prod2;
  logic [7:0]                   s;
  logic signed [RW-1:0]         rnd, r;
  logic signed [VW-1:0]         v, lo, hi;
  assign rdy3      = !q_valid || q_ready;
  assign rdy2      = !v2 || rdy3;
  assign rdy1      = !v1 || rdy2;
  assign acc_ready = rdy1;
  assign sat_xfer  = q_valid && q_ready && sat_flag;
  always_comb begin
    s    = (8'(shift_clip_src(sh2)) > 8'd48) ? 8'd48 : 8'(sh2);
    rnd  = (s == 8'd0) ? '0 : RW'(1) <<< (s - 8'd1);
    r    = (RW'(prod2) + rnd) >>> s;
    v    = VW'(r) + VW'(zp2);
    hi   = VW'(127);
`ifdef REQUANT_RELU_EN
    lo   = VW'(zp2);
`else
    lo   = VW'(-128);
`endif
    q_nx   = (v > hi) ? 8'sd127 : (v < lo) ? lo[7:0] : v[7:0];
    sat_nx = (v > hi) || (v < lo);
  end
  function automatic logic [SHIFT_WIDTH-1:0] shift_clip_src(input logic [SHIFT_WIDTH-1:0] x);
    return x;
  endfunction
  // Valid bits move whenever the downstream slot is free; payloads only load behind a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sum1  <= '0;
      mult1 <= '0;
      sh1   <= '0;
      zp1   <= '0;
    end else if (rdy1) begin
      v1 <= acc_valid;
      if (acc_valid) begin
        sum1  <= $signed({acc_in[ACC_WIDTH-1], acc_in}) + $signed({bias[ACC_WIDTH-1], bias});
        mult1 <= mult;
        sh1   <= shift;
        zp1   <= zero_point;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      prod2 <= '0;
      sh2   <= '0;
      zp2   <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        prod2 <= $signed({{MULT_WIDTH{sum1[SW-1]}}, sum1}) * $signed({{SW{mult1[MULT_WIDTH-1]}}, mult1});
        sh2   <= sh1;
        zp2   <= zp1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid  <= 1'b0;
      q_out    <= '0;
      sat_flag <= 1'b0;
    end else if (rdy3) begin
      q_valid <= v2;
      if (v2) begin
        q_out    <= q_nx;
        sat_flag <= sat_nx;
      end
    end
  end
  // Clear wins, but a saturated transfer in the same cycle still counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (sat_clr) sat_count <= sat_xfer ? CNT_WIDTH'(1) : '0;
    else if (sat_xfer && !(&sat_count)) sat_count <= sat_count + CNT_WIDTH'(1);
  end
endmodule
